// File: rtl/arcade_input_map.sv
// Player-input front end: PS/2 key events and two pads merged into the
// registered JOY/JOY2 control words, with optional SOCD cleaning and coin stretching.
module arcade_input_map #(
    parameter int COIN_CYCLES  = 1_500_000,
    parameter bit SOCD_NEUTRAL = 1'b1
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        clear,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [7:0]  joy1,
    output logic [7:0]  joy2
);
    localparam int            CW        = $clog2(COIN_CYCLES + 1);
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);

    logic          armed_q, armed_d;
    logic          tog_q, tog_d;
    logic          key_event;
    logic [15:0]   key_hit;
    logic [15:0]   key_q, key_d;
    logic [13:0]   pad_q, pad_d;
    logic [1:0]    coin_lvl;
    logic [1:0]    c_q, c_d;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [6:0]    lvl1, lvl2;
    logic [7:0]    joy1_q, joy1_d;
    logic [7:0]    joy2_q, joy2_d;
    logic          unused_pad_hi;

    assign unused_pad_hi = ^{joystick_0[15:8], joystick_1[15:8]};

    function automatic logic [6:0] socd_fix(input logic [6:0] lvl);
        logic [6:0] r;
        r = lvl;
        if (SOCD_NEUTRAL) begin
            if (r[0] && r[1]) r[1:0] = 2'b00;
            if (r[2] && r[3]) r[3:2] = 2'b00;
        end
        return r;
    endfunction

    // key_q / key_hit layout: [15:8] player 2, [7:0] player 1, same bit order as joy
    always_comb begin
        armed_d   = 1'b1;
        tog_d     = ps2_key[10];
        key_event = armed_q && (ps2_key[10] != tog_q);
        key_hit   = '0;
        case (ps2_key[7:0])
            8'h75:   key_hit[3] = 1'b1;
            8'h72:   key_hit[2] = 1'b1;
            8'h6B:   key_hit[1] = 1'b1;
            8'h74:   key_hit[0] = 1'b1;
            default: ;
        endcase
        if (!ps2_key[8]) begin
            case (ps2_key[7:0])
                8'h14:        key_hit[4]  = 1'b1;
                8'h29:        key_hit[5]  = 1'b1;
                8'h05, 8'h16: key_hit[6]  = 1'b1;
                8'h2E:        key_hit[7]  = 1'b1;
                8'h34:        key_hit[8]  = 1'b1;
                8'h23:        key_hit[9]  = 1'b1;
                8'h2B:        key_hit[10] = 1'b1;
                8'h2D:        key_hit[11] = 1'b1;
                8'h1C:        key_hit[12] = 1'b1;
                8'h1B:        key_hit[13] = 1'b1;
                8'h06, 8'h1E: key_hit[14] = 1'b1;
                8'h36:        key_hit[15] = 1'b1;
                default:      ;
            endcase
        end
        key_d = key_q;
        if (clear) begin
            key_d = '0;
        end else if (key_event) begin
            key_d = (key_q & ~key_hit) | (key_hit & {16{ps2_key[9]}});
        end
    end

    // Coin edge uses the raw pad bit so a clear does not create a false edge on release
    always_comb begin
        coin_lvl = {key_q[15] | joystick_1[7], key_q[7] | joystick_0[7]};
        c_d      = coin_lvl;
        for (int p = 0; p < 2; p++) begin
            cnt_d[p] = (cnt_q[p] != '0) ? cnt_q[p] - CW'(1) : '0;
            if (clear) begin
                cnt_d[p] = '0;
            end else if (coin_lvl[p] && !c_q[p] && (cnt_q[p] == '0)) begin
                cnt_d[p] = COIN_LOAD;
            end
        end
    end

    always_comb begin
        pad_d  = clear ? '0 : {joystick_1[6:0], joystick_0[6:0]};
        lvl1   = key_q[6:0]  | pad_q[6:0];
        lvl2   = key_q[14:8] | pad_q[13:7];
        joy1_d = {cnt_q[0] != '0, socd_fix(lvl1)};
        joy2_d = {cnt_q[1] != '0, socd_fix(lvl2)};
        if (clear) begin
            joy1_d = '0;
            joy2_d = '0;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed_q  <= 1'b0;
            tog_q    <= 1'b0;
            key_q    <= '0;
            pad_q    <= '0;
            c_q      <= '0;
            cnt_q[0] <= '0;
            cnt_q[1] <= '0;
            joy1_q   <= '0;
            joy2_q   <= '0;
        end else begin
            armed_q  <= armed_d;
            tog_q    <= tog_d;
            key_q    <= key_d;
            pad_q    <= pad_d;
            c_q      <= c_d;
            cnt_q[0] <= cnt_d[0];
            cnt_q[1] <= cnt_d[1];
            joy1_q   <= joy1_d;
            joy2_q   <= joy2_d;
        end
    end

    assign joy1 = joy1_q;
    assign joy2 = joy2_q;

endmodule

// File: tb/tb_arcade_input_map.sv
// Bench for arcade_input_map: directed scenarios then random traffic, all
// compared every cycle against a time-based reference model.
module tb_arcade_input_map;
    localparam int COIN_N = 8;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic        clear = 1'b0;
    logic [10:0] ps2_key = {1'b1, 1'b1, 1'b0, 8'h14};
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic [7:0]  joy1, joy2, joy1_raw, joy2_raw;

    int checks = 0;
    int errors = 0;

    arcade_input_map #(.COIN_CYCLES(COIN_N), .SOCD_NEUTRAL(1'b1)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .clear(clear), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .joy1(joy1), .joy2(joy2));

    arcade_input_map #(.COIN_CYCLES(COIN_N), .SOCD_NEUTRAL(1'b0)) dut_raw (
        .clk_sys(clk_sys), .reset_n(reset_n), .clear(clear), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .joy1(joy1_raw), .joy2(joy2_raw));

    always #5 clk_sys = ~clk_sys;

    // Reference model: held keys per player, pad levels, coin pulses as start times
    int       cyc = 0;
    bit       m_armed, m_tog;
    bit [7:0] m_key [2];
    bit [7:0] m_pad [2];
    bit       m_prev_lvl [2];
    int       m_start [2];
    bit [7:0] m_exp [2];
    bit [7:0] m_exp_raw [2];

    function automatic int key_slot(input bit [7:0] code, input bit ext);
        case (code)
            8'h75: return 3;
            8'h72: return 2;
            8'h6B: return 1;
            8'h74: return 0;
            default: ;
        endcase
        if (ext) return -1;
        case (code)
            8'h14: return 4;
            8'h29: return 5;
            8'h05, 8'h16: return 6;
            8'h2E: return 7;
            8'h2D: return 8 + 3;
            8'h2B: return 8 + 2;
            8'h23: return 8 + 1;
            8'h34: return 8 + 0;
            8'h1C: return 8 + 4;
            8'h1B: return 8 + 5;
            8'h06, 8'h1E: return 8 + 6;
            8'h36: return 8 + 7;
            default: return -1;
        endcase
    endfunction

    function automatic bit [7:0] shape(input bit [7:0] lvl, input bit coin, input bit socd);
        bit [7:0] r;
        r = lvl;
        r[7] = coin;
        if (socd && r[0] && r[1]) r[1:0] = 2'b00;
        if (socd && r[2] && r[3]) r[3:2] = 2'b00;
        return r;
    endfunction

    task automatic model_reset();
        m_armed = 0;
        m_tog = 0;
        for (int p = 0; p < 2; p++) begin
            m_key[p] = 0; m_pad[p] = 0; m_prev_lvl[p] = 0;
            m_start[p] = -1000; m_exp[p] = 0; m_exp_raw[p] = 0;
        end
    endtask

    task automatic model_edge();
        bit [15:0] jin [2];
        bit coin_on, lvlc;
        int s;
        jin[0] = joystick_0;
        jin[1] = joystick_1;
        for (int p = 0; p < 2; p++) begin
            coin_on = (cyc > m_start[p]) && (cyc <= m_start[p] + COIN_N);
            m_exp[p]     = clear ? 8'h00 : shape(m_key[p] | m_pad[p], coin_on, 1'b1);
            m_exp_raw[p] = clear ? 8'h00 : shape(m_key[p] | m_pad[p], coin_on, 1'b0);
            lvlc = m_key[p][7] | jin[p][7];
            if (clear) m_start[p] = -1000;
            else if (lvlc && !m_prev_lvl[p] && !coin_on) m_start[p] = cyc;
            m_prev_lvl[p] = lvlc;
            m_pad[p] = clear ? 8'h00 : {1'b0, jin[p][6:0]};
        end
        if (!m_armed) begin
            m_armed = 1;
            m_tog = ps2_key[10];
        end else if (ps2_key[10] != m_tog) begin
            m_tog = ps2_key[10];
            s = key_slot(ps2_key[7:0], ps2_key[8]);
            if (s >= 0 && !clear) m_key[s / 8][s % 8] = ps2_key[9];
        end
        if (clear) begin
            m_key[0] = 0;
            m_key[1] = 0;
        end
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_sys);
        #1;
        chk("joy1", joy1, m_exp[0]);
        chk("joy2", joy2, m_exp[1]);
        chk("joy1_raw", joy1_raw, m_exp_raw[0]);
        chk("joy2_raw", joy2_raw, m_exp_raw[1]);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic key_event(input bit [7:0] code, input bit ext, input bit pressed);
        ps2_key = {~ps2_key[10], pressed, ext, code};
        step();
    endtask

    // Runs n cycles with the coin pad bit of one player held for the given cycle numbers
    task automatic coin_run(input int n, input int hold_a, input int hold_b,
                            input int gap_lo, input int gap_hi, output int hi);
        hi = 0;
        for (int i = 0; i < n; i++) begin
            joystick_1[7] = (i < hold_a) || (i >= gap_lo && i < gap_hi) || (i < hold_b);
            step();
            if (joy2[7]) hi++;
        end
        joystick_1[7] = 1'b0;
    endtask

    bit [7:0] codes [20] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h29, 8'h05, 8'h16, 8'h2E,
                             8'h2D, 8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h06, 8'h1E, 8'h36,
                             8'h11, 8'h5A};

    initial begin
        int hi;
        int r;
        model_reset();
        #2;
        chk("reset_joy1", joy1, 8'h00);
        chk("reset_joy2", joy2, 8'h00);
        @(negedge clk_sys);
        reset_n = 1'b1;

        // Toggle already high with fire pressed at reset release must only arm
        steps(4);
        chk("arm_fire", joy1, 8'h00);

        // Jump key press/release, two-cycle latency
        key_event(8'h29, 1'b0, 1'b1);
        chk("jump_lat1", {7'b0, joy1[5]}, 8'h00);
        step();
        chk("jump_on", {7'b0, joy1[5]}, 8'h01);
        key_event(8'h29, 1'b0, 1'b0);
        step();
        chk("jump_off", {7'b0, joy1[5]}, 8'h00);

        // Extended arrows and SOCD
        key_event(8'h6B, 1'b1, 1'b1);
        step();
        key_event(8'h74, 1'b1, 1'b1);
        step();
        chk("socd_lr", {6'b0, joy1[1:0]}, 8'h00);
        chk("raw_lr", {6'b0, joy1_raw[1:0]}, 8'h03);
        key_event(8'h74, 1'b1, 1'b0);
        step();
        chk("socd_left", {6'b0, joy1[1:0]}, 8'h02);
        key_event(8'h6B, 1'b1, 1'b0);
        key_event(8'h14, 1'b1, 1'b1);
        step();
        chk("ext_fire_ignored", joy1, 8'h00);

        // Player separation
        joystick_0 = 16'h0010;
        joystick_1 = 16'h0008;
        steps(2);
        chk("sep_joy1", joy1, 8'h10);
        chk("sep_joy2", joy2, 8'h08);
        joystick_0 = '0;
        joystick_1 = '0;
        steps(2);

        // Coin stretching
        coin_run(24, 3, 0, 0, 0, hi);
        chk("coin_short", 8'(hi), 8'(COIN_N));
        coin_run(32, 20, 0, 0, 0, hi);
        chk("coin_long", 8'(hi), 8'(COIN_N));
        coin_run(24, 2, 0, 4, 6, hi);
        chk("coin_retrig", 8'(hi), 8'(COIN_N));

        // Clear with fire held and coin counter at 5
        joystick_0 = 16'h0090;
        steps(4);
        clear = 1'b1;
        step();
        chk("clear_joy1", joy1, 8'h00);
        clear = 1'b0;
        hi = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (joy1[7]) hi++;
        end
        chk("clear_no_coin", 8'(hi), 8'h00);
        chk("clear_fire_back", joy1, 8'h10);
        joystick_0 = '0;
        steps(2);

        // Event arriving during clear is discarded
        clear = 1'b1;
        key_event(8'h29, 1'b0, 1'b1);
        clear = 1'b0;
        steps(2);
        chk("clear_event_drop", joy1, 8'h00);

        // Asynchronous reset in the middle of a coin pulse
        joystick_1[7] = 1'b1;
        steps(3);
        reset_n = 1'b0;
        #1;
        chk("async_rst_joy2", joy2, 8'h00);
        chk("async_rst_joy1", joy1, 8'h00);
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
        joystick_1[7] = 1'b0;
        steps(12);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 30) begin
                ps2_key = {~ps2_key[10], 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 3) == 0), codes[$urandom_range(0, 19)]};
            end else if (r < 40) begin
                ps2_key[9:0] = 10'($urandom);
            end
            if ($urandom_range(0, 9) == 0) joystick_0 = 16'($urandom);
            if ($urandom_range(0, 9) == 0) joystick_1 = 16'($urandom);
            clear = ($urandom_range(0, 59) == 0);
            step();
        end
        clear = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/arcade_input_map.md
# arcade_input_map

Player-input front end for the Moon Patrol core. It sits between `hps_io` (PS/2 key events and USB joysticks) and `target_top`, and produces the two 8-bit `JOY`/`JOY2` control words. It does the following:
- decodes PS/2 make/break events into held-key state;
- merges that state with a separate joystick per player;
- optionally neutralises opposing directions;
- stretches coin inputs into fixed-length pulses the game CPU can reliably sample.

## Interface
Parameters:
- `COIN_CYCLES`, default 1_500_000: coin pulse length in `clk_sys` cycles (50 ms at 30 MHz). Legal range is ≥ 1. Counter width is `$clog2(COIN_CYCLES+1)`.
- `SOCD_NEUTRAL`, default 1: when 1, left+right gives neither and up+down gives neither. When 0, inputs pass through raw.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: one clock; reset is asynchronous and active-low.
- `clear`, in, 1: synchronous release-all (driven by ROM download or focus loss).
- `ps2_key`, in, 11: bit10 is the event toggle, bit9 is pressed, bit8 is extended (E0), [7:0] is the scan code.
- `joystick_0`, in, 16: player 1 pad.
- `joystick_1`, in, 16: player 2 pad.
- `joy1`, out, 8: `{coin,start,jump,fire,up,down,left,right}` to `JOY`.
- `joy2`, out, 8: same layout, to `JOY2`.

Pad bit map (both pads): [0] right, [1] left, [2] down, [3] up, [4] fire, [5] jump, [6] start, [7] coin.

## Operation
- Event detect:
  - `tog_q` register plus an `armed` flag.
  - The first edge after reset loads `tog_q` from `ps2_key[10]`, sets `armed`, and decodes nothing.
  - After that, an edge where `ps2_key[10] != tog_q` is one event. On that edge, `tog_q` updates and the matched key register is written with `ps2_key[9]`.
- Key map. Arrow codes match with bit8 either 0 or 1; all other keys require bit8 = 0.
  - P1: 75 up, 72 down, 6B left, 74 right, 14 fire, 29 jump, 05/16 start, 2E coin.
  - P2: 2D up, 2B down, 23 left, 34 right, 1C fire, 1B jump, 06/1E start, 36 coin.
  - Unmapped codes have no effect.
- Merge: per player, level = key register OR registered pad bit. P1 takes `joystick_0`, P2 takes `joystick_1`.
- SOCD (when enabled): if left and right are both set, clear both; same rule for up and down.
- Coin stretcher, independent per player:
  - Registered coin level `c_q`.
  - When the level is 1, `c_q` is 0, and the counter is 0, load the counter with `COIN_CYCLES`.
  - The coin output bit is high while the counter is ≠ 0. The counter decrements once per cycle and saturates at 0.
  - A rising edge while the counter is ≠ 0 is ignored; no retrigger or extension.
  - A source still held when the counter reaches 0 does not retrigger; a new rising edge is required.
- `clear`, highest priority:
  - Clears all key registers, both coin counters, the pad input registers and both outputs.
  - Loads `c_q` with the current coin level so no edge is seen on release.
  - `tog_q` keeps tracking; an event arriving during `clear` is consumed and discarded.

## Timing
- All outputs are registered. Reset value of `joy1`, `joy2`, key registers, pad registers, counters, `tog_q`, `c_q` and `armed` is 0.
- Key path: toggle change present before edge k → key register at edge k → `joy` valid after edge k+1 (2-cycle latency).
- Pad path: pad register at edge k → `joy` after edge k+1 (2 cycles).
- Coin path: source rises before edge k → `c_q`/counter load at edge k → coin bit high from edge k+1 for exactly `COIN_CYCLES` cycles.
- Simultaneous key event and pad change are merged in the same output cycle.
- Assertion of `reset_n` low mid-pulse zeroes the outputs immediately (asynchronous).

## Test plan
- Key press/release: toggle with code 0x29, pressed=1 → `joy1[5]`=1 two cycles later; toggle with pressed=0 → back to 0 after 2 cycles.
- Extended arrow and SOCD:
  - `{E0,6B}` press then `{E0,74}` press with `SOCD_NEUTRAL`=1 → `joy1[1:0]`=00.
  - Release 0x74 → `joy1[1:0]`=10.
  - With `SOCD_NEUTRAL`=0 → 11 while both are held.
- Coin stretch (`COIN_CYCLES`=8):
  - `joystick_1[7]` held 3 cycles → `joy2[7]` high exactly 8 cycles.
  - Held 20 cycles → still exactly 8.
  - Second rising edge at cycle 4 of the pulse → no extension.
- Reset arming: `ps2_key[10]`=1 with code 0x14 and pressed=1 at reset release → no `joy1[4]` assertion.
- `clear` mid-operation:
  - Fire held and coin counter at 5, assert `clear` one cycle → outputs 0 the next cycle and the counter is cancelled.
  - Coin source still high after `clear` → no new pulse.
- Player separation: `joystick_0`=0x0010, `joystick_1`=0x0008 → `joy1`=0x10, `joy2`=0x08.
